// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch controller and IF/ID pipeline register for the RV32 5-stage core.
// Runs a req/gnt/rvalid handshake to instruction memory; redirects squash in-flight fetches.
module fetch_stage_ctrl #(
    parameter int              ADDR_W    = 32,
    parameter int              INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0040_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_pc_i,
    input  logic               en_ifid_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_target_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               fetch_ready_o,
    output logic               ifid_valid_o,
    output logic [ADDR_W-1:0]  ifid_pc_o,
    output logic [INSTR_W-1:0] ifid_instr_o
);

    // Handshake: a request is accepted on a cycle with imem_req_o=1 and imem_gnt_i=1;
    // exactly one response (imem_rvalid_i=1) follows, and no new request is issued until it arrives.
    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] READY = 2'd3;

    logic [1:0]         state;
    logic [ADDR_W-1:0]  pc;
    logic               kill;
    logic [INSTR_W-1:0] buffer;
    logic [ADDR_W-1:0]  target_aligned;

    assign target_aligned = {redirect_target_i[ADDR_W-1:2], 2'b00};

    assign imem_req_o    = (state == REQ);
    assign imem_addr_o   = pc;
    assign fetch_ready_o = (state == READY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            kill         <= 1'b0;
            buffer       <= NOP_INSTR;
            ifid_valid_o <= 1'b0;
            ifid_pc_o    <= '0;
            ifid_instr_o <= NOP_INSTR;
        end else if (redirect_i && state != BOOT) begin
            // Redirect squashes whatever is in flight and bubbles IF/ID; ifid_pc is left as is.
            pc           <= target_aligned;
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= NOP_INSTR;
            case (state)
                REQ: begin
                    if (imem_gnt_i) begin
                        state <= WAIT;
                        kill  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state <= REQ;
                        kill  <= 1'b0;
                    end else begin
                        kill  <= 1'b1;
                    end
                end
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (imem_gnt_i) state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else begin
                            buffer <= imem_rdata_i;
                            state  <= READY;
                        end
                    end
                end
                default: begin
                    // READY: advance only when the hazard unit enables both PC and IF/ID.
                    if (en_pc_i && en_ifid_i) begin
                        ifid_pc_o    <= pc;
                        ifid_instr_o <= buffer;
                        ifid_valid_o <= 1'b1;
                        pc           <= pc + ADDR_W'(4);
                        state        <= REQ;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: inputs change on negedge, outputs are checked on negedge.
module tb_fetch_stage_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        en_pc;
    logic        en_ifid;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        fetch_ready;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;

    int checks = 0;
    int errors = 0;

    fetch_stage_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .en_pc_i           (en_pc),
        .en_ifid_i         (en_ifid),
        .redirect_i        (redirect),
        .redirect_target_i (redirect_target),
        .imem_req_o        (imem_req),
        .imem_addr_o       (imem_addr),
        .imem_gnt_i        (imem_gnt),
        .imem_rvalid_i     (imem_rvalid),
        .imem_rdata_i      (imem_rdata),
        .fetch_ready_o     (fetch_ready),
        .ifid_valid_o      (ifid_valid),
        .ifid_pc_o         (ifid_pc),
        .ifid_instr_o      (ifid_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] addr);
        return addr + 32'h1000_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; en_pc = 1'b1; en_ifid = 1'b1; redirect = 1'b0;
        redirect_target = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        @(negedge clk);
        step();
        step();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_ready", 32'(fetch_ready), 32'd0);
        check("rst_valid", 32'(ifid_valid), 32'd0);
        check("rst_ifid_pc", ifid_pc, 32'd0);
        check("rst_ifid_instr", ifid_instr, NOP);
        check("rst_addr", imem_addr, RESET_PC);

        // Reset release, zero-wait memory
        rst_n = 1'b1;
        step();
        check("boot_req", 32'(imem_req), 32'd1);
        check("boot_addr", imem_addr, RESET_PC);
        imem_gnt = 1'b1;
        step();
        check("wait0_req", 32'(imem_req), 32'd0);
        check("wait0_ready", 32'(fetch_ready), 32'd0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_at(RESET_PC);
        step();
        check("ready0", 32'(fetch_ready), 32'd1);
        imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        step();
        check("adv0_pc", ifid_pc, RESET_PC);
        check("adv0_instr", ifid_instr, instr_at(RESET_PC));
        check("adv0_valid", 32'(ifid_valid), 32'd1);
        check("adv0_req", 32'(imem_req), 32'd1);
        check("adv0_addr", imem_addr, 32'h0040_0004);

        // Delayed grant (3 cycles) and delayed response (2 cycles)
        for (int i = 0; i < 3; i++) begin
            step();
            check("gnt_hold_req", 32'(imem_req), 32'd1);
            check("gnt_hold_addr", imem_addr, 32'h0040_0004);
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rv_wait_req", 32'(imem_req), 32'd0);
            check("rv_wait_ready", 32'(fetch_ready), 32'd0);
            step();
        end
        imem_rvalid = 1'b1; imem_rdata = instr_at(32'h0040_0004);
        en_pc = 1'b0;
        step();
        imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        check("rv_ready", 32'(fetch_ready), 32'd1);

        // Load-use stall in READY for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_ready", 32'(fetch_ready), 32'd1);
            check("stall_req", 32'(imem_req), 32'd0);
            check("stall_addr", imem_addr, 32'h0040_0004);
            check("stall_ifid_pc", ifid_pc, RESET_PC);
            check("stall_ifid_instr", ifid_instr, instr_at(RESET_PC));
        end
        en_pc = 1'b1;
        step();
        check("adv1_pc", ifid_pc, 32'h0040_0004);
        check("adv1_instr", ifid_instr, instr_at(32'h0040_0004));
        check("adv1_addr", imem_addr, 32'h0040_0008);
        check("adv1_req", 32'(imem_req), 32'd1);

        // Redirect while READY to unaligned target
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_at(32'h0040_0008);
        step();
        imem_rvalid = 1'b0;
        check("rd_ready", 32'(fetch_ready), 32'd1);
        redirect = 1'b1; redirect_target = 32'h0040_0103;
        step();
        redirect = 1'b0;
        check("rdr_valid", 32'(ifid_valid), 32'd0);
        check("rdr_instr", ifid_instr, NOP);
        check("rdr_ifid_pc", ifid_pc, 32'h0040_0004);
        check("rdr_req", 32'(imem_req), 32'd1);
        check("rdr_addr", imem_addr, 32'h0040_0100);

        // Redirect while WAIT; stale response must be dropped
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        redirect = 1'b1; redirect_target = 32'h0040_0200;
        step();
        redirect = 1'b0;
        check("rdw_req", 32'(imem_req), 32'd0);
        check("rdw_addr", imem_addr, 32'h0040_0200);
        step();
        check("rdw_ready", 32'(fetch_ready), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("rdw_stale_ready", 32'(fetch_ready), 32'd0);
        check("rdw_stale_req", 32'(imem_req), 32'd1);
        check("rdw_stale_addr", imem_addr, 32'h0040_0200);
        check("rdw_stale_instr", ifid_instr, NOP);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_at(32'h0040_0200);
        step();
        imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        step();
        check("rdw_adv_pc", ifid_pc, 32'h0040_0200);
        check("rdw_adv_instr", ifid_instr, instr_at(32'h0040_0200));
        check("rdw_adv_valid", 32'(ifid_valid), 32'd1);

        // Redirect in REQ without grant, then wrap of pc+4
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check("wrap_req", 32'(imem_req), 32'd1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_bubble", 32'(ifid_valid), 32'd0);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_at(32'hFFFF_FFFC);
        step();
        imem_rvalid = 1'b0;
        step();
        check("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        check("wrap_next_addr", imem_addr, 32'h0000_0000);

        // Reset during WAIT; late response must be ignored
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst_n = 1'b0;
        step();
        check("rw_req", 32'(imem_req), 32'd0);
        check("rw_valid", 32'(ifid_valid), 32'd0);
        check("rw_addr", imem_addr, RESET_PC);
        rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        check("rw_boot_ready", 32'(fetch_ready), 32'd0);
        check("rw_boot_req", 32'(imem_req), 32'd1);
        step();
        imem_rvalid = 1'b0;
        check("rw_req_hold", 32'(imem_req), 32'd1);
        check("rw_req_ready", 32'(fetch_ready), 32'd0);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_at(RESET_PC);
        step();
        imem_rvalid = 1'b0;
        step();
        check("rw_adv_pc", ifid_pc, RESET_PC);
        check("rw_adv_instr", ifid_instr, instr_at(RESET_PC));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
